// File: rtl/traffic_light_fsm.sv
// Intersection phase sequencer driven by the 1 s tick: NS/EW green-yellow-all-red
// cycle with an optional pedestrian walk phase and a night flashing-yellow mode.
module traffic_light_fsm #(
  parameter int unsigned T_GREEN   = 10,
  parameter int unsigned T_YELLOW  = 3,
  parameter int unsigned T_ALL_RED = 2,
  parameter int unsigned T_PED     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       ped_req,
  input  logic       night_mode,
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic       ped_walk,
  output logic [7:0] sec_left,
  output logic [2:0] phase
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned ST_W   = 3;
  localparam int unsigned LAMP_W = 7;

  localparam logic [ST_W-1:0] NS_GREEN  = 3'd0;
  localparam logic [ST_W-1:0] NS_YELLOW = 3'd1;
  localparam logic [ST_W-1:0] CLR_A     = 3'd2;
  localparam logic [ST_W-1:0] EW_GREEN  = 3'd3;
  localparam logic [ST_W-1:0] EW_YELLOW = 3'd4;
  localparam logic [ST_W-1:0] CLR_B     = 3'd5;
  localparam logic [ST_W-1:0] PED_WALK  = 3'd6;
  localparam logic [ST_W-1:0] FLASH     = 3'd7;

  localparam logic [CNT_W-1:0] LD_GREEN   = CNT_W'(T_GREEN);
  localparam logic [CNT_W-1:0] LD_YELLOW  = CNT_W'(T_YELLOW);
  localparam logic [CNT_W-1:0] LD_ALL_RED = CNT_W'(T_ALL_RED);
  localparam logic [CNT_W-1:0] LD_PED     = CNT_W'(T_PED);

  // Lamp vector order: {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk}
  localparam logic [LAMP_W-1:0] LAMPS_RST = 7'b100_100_0;

  logic              tick_q;
  logic              tick_ev;
  logic [ST_W-1:0]   state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ped_pending_q, ped_pending_d;
  logic              flash_ph_q, flash_ph_d;
  logic [LAMP_W-1:0] lamps_q, lamps_d;

  assign tick_ev = tick & ~tick_q;

  // Moore lamp decode; FLASH shows only the blinking yellows.
  function automatic logic [LAMP_W-1:0] decode_lamps(input logic [ST_W-1:0] st,
                                                     input logic            ph);
    logic ns_g, ns_y, ew_g, ew_y, flash;
    flash = (st == FLASH);
    ns_g  = (st == NS_GREEN);
    ns_y  = (st == NS_YELLOW) | (flash & ph);
    ew_g  = (st == EW_GREEN);
    ew_y  = (st == EW_YELLOW) | (flash & ph);
    return {~flash & ~ns_g & ~ns_y, ns_y, ns_g,
            ~flash & ~ew_g & ~ew_y, ew_y, ew_g,
            (st == PED_WALK)};
  endfunction

  // Duration loaded on entry to each timed state.
  function automatic logic [CNT_W-1:0] load_for(input logic [ST_W-1:0] st);
    logic [CNT_W-1:0] ld;
    ld = '0;
    case (st)
      NS_GREEN, EW_GREEN:  ld = LD_GREEN;
      NS_YELLOW, EW_YELLOW: ld = LD_YELLOW;
      CLR_A, CLR_B:        ld = LD_ALL_RED;
      PED_WALK:            ld = LD_PED;
      default:             ld = '0;
    endcase
    return ld;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_q        <= 1'b0;
      state_q       <= CLR_B;
      cnt_q         <= LD_ALL_RED;
      ped_pending_q <= 1'b0;
      flash_ph_q    <= 1'b0;
      lamps_q       <= LAMPS_RST;
    end else begin
      tick_q        <= tick;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ped_pending_q <= ped_pending_d;
      flash_ph_q    <= flash_ph_d;
      lamps_q       <= lamps_d;
    end
  end

  // Next-state: night mode outranks counter expiry on the same tick event.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    flash_ph_d = flash_ph_q;
    if (tick_ev) begin
      if (night_mode && (state_q != FLASH)) begin
        state_d    = FLASH;
        cnt_d      = '0;
        flash_ph_d = 1'b1;
      end else if (state_q == FLASH) begin
        flash_ph_d = ~flash_ph_q;
        if (!night_mode) begin
          state_d = CLR_B;
          cnt_d   = LD_ALL_RED;
        end
      end else if (cnt_q > CNT_W'(1)) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        case (state_q)
          NS_GREEN:  state_d = NS_YELLOW;
          NS_YELLOW: state_d = CLR_A;
          CLR_A:     state_d = EW_GREEN;
          EW_GREEN:  state_d = EW_YELLOW;
          EW_YELLOW: state_d = CLR_B;
          CLR_B:     state_d = ped_pending_q ? PED_WALK : NS_GREEN;
          PED_WALK:  state_d = NS_GREEN;
          default:   state_d = CLR_B;
        endcase
        cnt_d = load_for(state_d);
      end
    end
  end

  // Entering the walk consumes the request, even one arriving on that edge.
  always_comb begin
    ped_pending_d = ped_pending_q;
    if ((state_d == PED_WALK) && (state_q != PED_WALK)) begin
      ped_pending_d = 1'b0;
    end else if (ped_req && (state_q != PED_WALK)) begin
      ped_pending_d = 1'b1;
    end
  end

  always_comb begin
    lamps_d = decode_lamps(state_d, flash_ph_d);
  end

  assign {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, ped_walk} = lamps_q;
  assign sec_left = cnt_q;
  assign phase    = state_q;

endmodule
